// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and access-legality helper for the
// dmem_ctrl data-memory controller.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Natural alignment: halves on even bytes, words on 4-byte boundaries; size 11 never legal.
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane logic for dmem_ctrl: merges store data into the old word and
// extracts/extends load data from the addressed word.
module dmem_align (
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   output logic [31:0] merged,
   output logic [31:0] loaded
);
   import dmem_pkg::*;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = word[{lane, 3'b000} +: 8];
   assign ld_half = word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: default assignment first so every path drives merged and no latch is inferred.
      merged = word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8]    = wdata[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

   always_comb begin
      loaded = word;
      case (size)
         SZ_BYTE: loaded = {{24{ld_byte[7] & ~uns}}, ld_byte};
         SZ_HALF: loaded = {{16{ld_half[15] & ~uns}}, ld_half};
         default: loaded = word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready/rvalid handshake with configurable wait
// states, byte/half/word access, alignment error flagging and a debug read port.
module dmem_ctrl #(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_STATES = 0,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req,
   input  logic             we,
   input  logic [1:0]       size,
   input  logic             uns,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic             ready,
   output logic             rvalid,
   output logic [31:0]      rdata,
   output logic             err,
   input  logic [IDX_W-1:0] dbg_idx,
   output logic [31:0]      dbg_data
);
   import dmem_pkg::*;

   localparam int CNT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

   state_t            state, state_nx;
   logic [3:0]        cnt;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              we_q, uns_q;
   logic [1:0]        size_q, lane_q;
   logic [IDX_W-1:0]  idx_q;
   logic [31:0]       wdata_q;

   logic              a_we, a_uns, a_err;
   logic [1:0]        a_size, a_lane;
   logic [IDX_W-1:0]  a_idx;
   logic [31:0]       a_wdata, merged, loaded;
   logic              accept, commit;

   // Address bits above the array index wrap by design.
   logic unused_addr;
   assign unused_addr = ^addr[31:IDX_W+2];

   assign ready    = (state == IDLE);
   assign rvalid   = (state == RESP);
   assign accept   = req && ready;
   assign dbg_data = mem[dbg_idx];

   // In IDLE the access is still on the inputs; with no wait states it commits on its acceptance edge.
   always_comb begin
      if (state == IDLE) begin
         a_we = we;   a_size = size;   a_uns = uns;
         a_lane = addr[1:0];   a_idx = addr[IDX_W+1:2];   a_wdata = wdata;
      end else begin
         a_we = we_q; a_size = size_q; a_uns = uns_q;
         a_lane = lane_q;      a_idx = idx_q;             a_wdata = wdata_q;
      end
   end

   assign a_err = access_err(a_size, a_lane);

   dmem_align u_align (
      .word   (mem[a_idx]),
      .wdata  (a_wdata),
      .size   (a_size),
      .lane   (a_lane),
      .uns    (a_uns),
      .merged (merged),
      .loaded (loaded)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT:    if (cnt == 4'd0) state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   assign commit = (state_nx == RESP);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= 4'(CNT_INIT);
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   // NOTE: the array shares this block only so reset can block a commit; its contents are never cleared.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata   <= 32'd0;
         err     <= 1'b0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= SZ_BYTE;
         lane_q  <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'd0;
      end else begin
         if (accept) begin
            we_q    <= we;
            uns_q   <= uns;
            size_q  <= size;
            lane_q  <= addr[1:0];
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
         end
         if (commit) begin
            err   <= a_err;
            rdata <= (a_we || a_err) ? 32'd0 : loaded;
            if (a_we && !a_err)
               mem[a_idx] <= merged;
         end
      end
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory block that is the next generation of the single-cycle word-only data memory. It adds byte and halfword stores, sign- and zero-extended loads, and a req/ready/rvalid handshake with configurable wait states. It also flags misaligned and illegal accesses and provides a debug read port. It sits between the pipelined CPU's memory stage and the on-chip RAM array in the top-level computer.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words in the array; power of 2, minimum 4.
WAIT_STATES, 0, extra cycles between request acceptance and response; range 0..15.
IDX_W, $clog2(DEPTH_WORDS), word index width; derived, never overridden.

Ports:
clk  in  1  CPU clock, rising edge
rstn  in  1  asynchronous active-low reset
req  in  1  access request
we  in  1  1 = store, 0 = load; sampled with req
size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
addr  in  32  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  out  1  controller can accept a request this cycle
rvalid  out  1  one-cycle response strobe
rdata  out  32  load result, extended; 0 for stores and errors
err  out  1  qualifies rvalid: misaligned or illegal access
dbg_idx  in  IDX_W  debug word index
dbg_data  out  32  combinational read of array[dbg_idx]

Behaviour:
- Reset (rstn low, async):
  - State goes to IDLE; rvalid=0, rdata=0, err=0, wait counter=0.
  - Array contents are not reset.
  - An in-flight access is dropped; an uncommitted store never writes.
- ready = (state==IDLE). It is combinational from state only, never from req.
- Acceptance: req && ready at a rising edge. The controller latches we, size, uns, addr and wdata at that edge.
- FSM:
  - IDLE -> WAIT when accepted and WAIT_STATES>0; the counter loads WAIT_STATES-1.
  - IDLE -> RESP when accepted and WAIT_STATES==0.
  - WAIT: counter decrements each cycle; goes to RESP at the edge where the counter is 0.
  - RESP -> IDLE unconditionally.
- rvalid is high exactly during RESP, so the response arrives WAIT_STATES+1 cycles after acceptance. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- A req asserted while ready=0 is ignored; the master must hold req until accepted.
- Store commit: the array is written at the edge entering RESP, only if err=0.
  - Byte lane = addr[1:0]; the store writes wdata[7:0] into that lane.
  - Half lane = addr[1]; the store writes wdata[15:0].
  - Word stores write all 32 bits.
  - Untouched lanes keep their value (read-modify-write inside the array or per-lane write enables).
- Load data: the array is read at the edge entering RESP. The selected byte or half is extracted, then sign-extended when uns=0 and zero-extended when uns=1; uns is ignored for word loads. rdata is registered and holds its value until the next RESP.
- Error cases set err=1 at RESP with rdata=0 and no write:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - size=11.
- Word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- dbg_data reflects the array contents combinationally. It shows a store's new value from the cycle after its commit edge.
- If rstn deasserts during a cycle with req high, the request may be accepted at the first rising edge after deassertion.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum {IDLE, WAIT, RESP};
  - a function computing the misalign/illegal flag.
- One sub-module, dmem_align: purely combinational lane logic. It produces the store merge (old word, wdata, size, addr[1:0] -> new word) and the load extract/extend (word, size, addr[1:0], uns -> rdata).
- dmem_ctrl owns the FSM, counter, registers and array.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rvalid 1 cycle after each acceptance; load rdata=0xDEADBEEF, err=0; dbg_idx=4 gives 0xDEADBEEF.
- Store byte 0x80 at 0x13 over 0x11223344, then load byte signed at 0x13 -> rdata=0xFFFFFF80; same load with uns=1 -> 0x00000080; word load -> 0x80223344.
- Store half 0xBEEF at 0x22 over 0x00000000, then load half signed at 0x22 -> 0xFFFFBEEF; load word -> 0xBEEF0000.
- Misaligned: word store at 0x31 and half load at 0x33, then size=11 -> each gives err=1, rdata=0; word at 0x30 is unchanged.
- WAIT_STATES=3: hold req continuously -> ready low for 4 cycles after each acceptance; rvalid exactly 4 cycles after acceptance; one access per 5 cycles.
- WAIT_STATES=3: accept a store, pull rstn low 2 cycles later -> rvalid=0, state IDLE, the target word keeps its old value; the next access after release completes normally.
- Wrap: DEPTH_WORDS=128, store 0x12345678 at 0x204 -> a load at 0x004 returns 0x12345678.
